// File: rtl/synth_audio_pkg.sv
// Shared audio-path types and sample conversion for the NCO, mixer and I2S output stage.
// Latency: none (package only). Backpressure: not applicable.
package synth_audio_pkg;

    localparam int SAMPLE_W = 8;
    localparam logic [SAMPLE_W-1:0] SAMPLE_MID = 8'h80;

    typedef enum logic {
        LR_LEFT  = 1'b0,
        LR_RIGHT = 1'b1
    } lr_e;

    // Offset-binary to two's complement, MSB-aligned in a width-bit word (8..32), returned in the low bits.
    function automatic logic [31:0] u8_to_signed_lj(input logic [SAMPLE_W-1:0] sample, input int width);
        logic [31:0] word;
        word = {~sample[SAMPLE_W-1], sample[SAMPLE_W-2:0], 24'b0};
        return word >> (32 - width);
    endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock divider: toggles bclk every HALF_DIV clk cycles and flags the cycle whose edge drops it.
// Latency: first rise HALF_DIV edges after reset, first fall at 2*HALF_DIV. Backpressure: none, free-running.
module i2s_bclk_gen #(
    parameter int HALF_DIV = 49
) (
    input  logic clk,
    input  logic rst,
    output logic bclk,
    output logic fall_evt
);

    localparam int CNT_W = $clog2(HALF_DIV + 1);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(HALF_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic             term;

    assign term     = (cnt == TERM);
    // High during the cycle whose rising clk edge takes bclk 1 -> 0.
    assign fall_evt = term & bclk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            bclk <= 1'b0;
        end else if (term) begin
            cnt  <= '0;
            bclk <= ~bclk;
        end else begin
            cnt  <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/i2s_tx.sv
// Mono Philips I2S transmitter with a one-sample holding register; I2S_TX_UNDERRUN_MUTE_EN mutes on underrun.
// Latency: MSB on SDATA one BCLK period after the frame latch. Backpressure: none, overwrite pulses OVERRUN.
module i2s_tx
    import synth_audio_pkg::*;
#(
    parameter int HALF_DIV = 49,
    parameter int W        = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [SAMPLE_W-1:0] SAMPLE_IN,
    input  logic                SAMPLE_STB,
    output logic                BCLK,
    output logic                LRCLK,
    output logic                SDATA,
    output logic                OVERRUN
);

    localparam int BC_W = $clog2(2 * W);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(2 * W - 1);
    localparam logic [BC_W-1:0] BC_HALF = BC_W'(W);

`ifdef I2S_TX_UNDERRUN_MUTE_EN
    localparam bit MUTE_ON_UNDERRUN = 1'b1;
`else
    localparam bit MUTE_ON_UNDERRUN = 1'b0;
`endif

    logic                fall_evt;
    logic                frame_latch;
    logic [BC_W-1:0]     bc;
    logic [BC_W-1:0]     bc_next;
    logic [SAMPLE_W-1:0] hold;
    logic                pending;
    logic [SAMPLE_W-1:0] frame_src;
    logic [W-1:0]        slot_word;
    logic [2*W-1:0]      shifter;

    i2s_bclk_gen #(
        .HALF_DIV (HALF_DIV)
    ) u_bclk_gen (
        .clk      (CLK),
        .rst      (RST),
        .bclk     (BCLK),
        .fall_evt (fall_evt)
    );

    always_comb begin
        bc_next     = (bc == BC_LAST) ? '0 : bc + BC_W'(1);
        frame_latch = fall_evt && (bc == BC_LAST);
        // A strobe landing on the latch edge bypasses the holding register.
        if (SAMPLE_STB) begin
            frame_src = SAMPLE_IN;
        end else if (MUTE_ON_UNDERRUN && !pending) begin
            frame_src = SAMPLE_MID;
        end else begin
            frame_src = hold;
        end
        slot_word = W'(u8_to_signed_lj(frame_src, W));
    end

    // Shifting out the old frame's last bit while loading the new one gives the I2S one-bit delay for free.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bc      <= BC_LAST;
            LRCLK   <= LR_RIGHT;
            SDATA   <= 1'b0;
            shifter <= '0;
        end else if (fall_evt) begin
            bc      <= bc_next;
            LRCLK   <= (bc_next >= BC_HALF) ? LR_RIGHT : LR_LEFT;
            SDATA   <= shifter[2*W-1];
            shifter <= frame_latch ? {slot_word, slot_word} : {shifter[2*W-2:0], 1'b0};
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hold    <= SAMPLE_MID;
            pending <= 1'b0;
            OVERRUN <= 1'b0;
        end else begin
            OVERRUN <= SAMPLE_STB && pending && !frame_latch;
            if (SAMPLE_STB) begin
                hold <= SAMPLE_IN;
            end
            if (frame_latch) begin
                pending <= 1'b0;
            end else if (SAMPLE_STB) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx at HALF_DIV=2, W=16: frame words reassembled from SDATA and checked against a scoreboard.
module tb_i2s_tx;

    localparam int HALF_DIV = 2;
    localparam int W        = 16;
    localparam int FRAME    = 4 * W * HALF_DIV;

`ifdef I2S_TX_UNDERRUN_MUTE_EN
    localparam bit MUTE = 1'b1;
`else
    localparam bit MUTE = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] SAMPLE_IN = 8'h80;
    logic       SAMPLE_STB = 1'b0;
    logic       BCLK;
    logic       LRCLK;
    logic       SDATA;
    logic       OVERRUN;

    int compared   = 0;
    int mismatched = 0;

    i2s_tx #(
        .HALF_DIV (HALF_DIV),
        .W        (W)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .SAMPLE_IN  (SAMPLE_IN),
        .SAMPLE_STB (SAMPLE_STB),
        .BCLK       (BCLK),
        .LRCLK      (LRCLK),
        .SDATA      (SDATA),
        .OVERRUN    (OVERRUN)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Scoreboard model: frame latch every FRAME edges starting at edge 4 after reset release.
    logic [15:0] stb_exp  = 16'h0000;
    logic [15:0] hold_exp = 16'h0000;
    logic        pend_exp = 1'b0;
    logic        exp_ovr  = 1'b0;
    logic        m_latch;
    logic [15:0] m_src;
    int          e = 0;
    logic [31:0] exp_q[$];

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            e        = 0;
            hold_exp = 16'h0000;
            pend_exp = 1'b0;
            exp_ovr  = 1'b0;
            exp_q.delete();
        end else begin
            e++;
            m_latch = (e >= 4) && (((e - 4) % FRAME) == 0);
            exp_ovr = SAMPLE_STB && pend_exp && !m_latch;
            if (m_latch) begin
                if (SAMPLE_STB)            m_src = stb_exp;
                else if (MUTE && !pend_exp) m_src = 16'h0000;
                else                        m_src = hold_exp;
                exp_q.push_back({m_src, m_src});
                pend_exp = 1'b0;
            end else if (SAMPLE_STB) begin
                pend_exp = 1'b1;
            end
            if (SAMPLE_STB) hold_exp = stb_exp;
        end
    end

    // Monitor: slot count follows BCLK falls; bits sampled on BCLK rises; slot 0 completes the prior frame.
    int          mslot = 2 * W - 1;
    logic        started = 1'b0;
    logic        pb = 1'b0;
    logic        ps = 1'b0;
    logic [31:0] acc = '0;
    logic [31:0] exp_w;

    always @(negedge CLK) begin
        if (RST) begin
            mslot   = 2 * W - 1;
            started = 1'b0;
            pb      = 1'b0;
            ps      = 1'b0;
            acc     = '0;
        end else begin
            if (SDATA !== ps) check("sdata_changes_on_fall", {pb, BCLK}, 32'd2);
            if (pb && !BCLK) mslot = (mslot + 1) % (2 * W);
            if (!pb && BCLK) begin
                if (mslot == 0) begin
                    check("lrclk_slot0", LRCLK, 0);
                    if (started) begin
                        acc = {acc[30:0], SDATA};
                        if (exp_q.size() == 0) begin
                            fail_now("frame_word_unexpected");
                        end else begin
                            exp_w = exp_q.pop_front();
                            check("frame_word", acc, exp_w);
                        end
                    end
                end else begin
                    if (mslot == W) check("lrclk_slotW", LRCLK, 1);
                    if (mslot == 1) begin
                        acc     = {31'b0, SDATA};
                        started = 1'b1;
                    end else begin
                        acc = {acc[30:0], SDATA};
                    end
                end
            end
            if (OVERRUN || exp_ovr) check("overrun", OVERRUN, exp_ovr);
            pb = BCLK;
            ps = SDATA;
        end
    end

    task automatic wait_off(input int off);
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while ((((e + FRAME - 4) % FRAME) != off) && (n < 4 * FRAME));
        if (n >= 4 * FRAME) fail_now("wait_off_timeout");
    endtask

    task automatic strobe(input logic [7:0] s, input logic [15:0] w);
        SAMPLE_IN  = s;
        stb_exp    = w;
        SAMPLE_STB = 1'b1;
        @(negedge CLK);
        SAMPLE_STB = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  smp;
        logic [15:0] word;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{8'hC0, 16'h4000};
        vecs[1] = '{8'h00, 16'h8000};
        vecs[2] = '{8'hFF, 16'h7F00};
        vecs[3] = '{8'h80, 16'h0000};
        vecs[4] = '{8'h10, 16'h9000};
        vecs[5] = '{8'h7F, 16'hFF00};
        vecs[6] = '{8'h01, 16'h8100};
        vecs[7] = '{8'hA5, 16'h2500};

        repeat (3) @(negedge CLK);
        check("rst_bclk", BCLK, 0);
        check("rst_lrclk", LRCLK, 1);
        check("rst_sdata", SDATA, 0);
        check("rst_overrun", OVERRUN, 0);

        // Release and edge timing; C0 strobed ahead of the first frame latch.
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK); #1;
        check("bclk_edge1", BCLK, 0);
        @(posedge CLK); #1;
        check("bclk_edge2", BCLK, 1);
        check("lrclk_edge2", LRCLK, 1);
        @(negedge CLK);
        SAMPLE_IN  = 8'hC0;
        stb_exp    = 16'h4000;
        SAMPLE_STB = 1'b1;
        @(posedge CLK); #1;
        SAMPLE_STB = 1'b0;
        check("lrclk_edge3", LRCLK, 1);
        @(posedge CLK); #1;
        check("lrclk_edge4", LRCLK, 0);
        check("bclk_edge4", BCLK, 0);
        repeat (7) @(posedge CLK);
        #1 check("sdata_slot1_msb", SDATA, 0);
        @(posedge CLK); #1;
        check("sdata_slot2", SDATA, 1);

        for (int i = 0; i < 8; i++) begin
            wait_off(40);
            strobe(vecs[i].smp, vecs[i].word);
        end

        // Overrun: two strobes in one frame, latest wins.
        wait_off(20);
        strobe(8'h10, 16'h9000);
        wait_off(60);
        strobe(8'h20, 16'hA000);
        check("overrun_pulse", OVERRUN, 1);
        @(negedge CLK);
        check("overrun_single", OVERRUN, 0);

        // Underrun: a full frame without strobes.
        wait_off(60);
        wait_off(60);

        // Bypass on the latch cycle with a sample already pending.
        wait_off(60);
        strobe(8'h10, 16'h9000);
        wait_off(127);
        strobe(8'h20, 16'hA000);
        check("bypass_no_overrun", OVERRUN, 0);
        wait_off(60);
        wait_off(60);

        // Reset mid-frame with a sample pending.
        wait_off(10);
        strobe(8'h00, 16'h8000);
        wait_off(50);
        #1 RST = 1'b1;
        #1;
        check("midrst_bclk", BCLK, 0);
        check("midrst_lrclk", LRCLK, 1);
        check("midrst_sdata", SDATA, 0);
        check("midrst_overrun", OVERRUN, 0);
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        repeat (3 * FRAME) @(negedge CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/i2s_tx.md
# i2s_tx

Serial audio output stage for the synth voice path. Accepts 8-bit unsigned samples from the NCO on a single-cycle strobe, buffers one sample, and transmits it as a mono (L = R) Philips I2S stream to an external DAC. It generates its own BCLK/LRCLK from the system clock, so the frame rate is independent of the NCO sample strobe. Overrun is flagged; underrun behaviour is compile-time selectable.

## Interface
- HALF_DIV, 49: CLK cycles per BCLK half-period. Range 1..4095. At 100 MHz: BCLK ≈ 1.02 MHz, fs ≈ 31.9 kHz.
- W, 16: bits per channel slot. Range 8..32. Frame = 2W BCLK periods.
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- SAMPLE_IN  in  8  unsigned offset-binary sample; 8'h80 = silence.
- SAMPLE_STB  in  1  one-cycle strobe; SAMPLE_IN is valid in that cycle. No backpressure.
- BCLK  out  1  bit clock.
- LRCLK  out  1  word select; 0 = left, 1 = right.
- SDATA  out  1  serial data, MSB first; changes only on BCLK falling edges.
- OVERRUN  out  1  one-cycle pulse when a pending sample is overwritten.

## Operation
- Divider counts 0..HALF_DIV-1. At terminal count it wraps and BCLK toggles. A 1→0 toggle is a "fall event".
- Bit counter bc (0..2W-1) advances on each fall event and wraps 2W-1→0. LRCLK = 0 for bc < W, otherwise 1. LRCLK is updated on the same fall event.
- Holding register HOLD (8 bits) and PENDING flag:
  - STB loads HOLD and sets PENDING.
  - If STB arrives while PENDING is already 1 and this is not a frame-latch cycle, HOLD is overwritten and OVERRUN pulses on the next cycle.
- Frame latch occurs on the fall event where bc becomes 0.
  - Source is SAMPLE_IN if STB is high in that same cycle (bypass), otherwise HOLD.
  - PENDING is cleared. No overrun is flagged in this cycle.
- Conversion: C = {~s[7], s[6:0], (W-8)'b0}, a signed, left-justified W-bit word. Frame word F = {C, C}.
- SDATA follows I2S one-bit delay:
  - In slot bc = k (1..2W-1), SDATA = F[2W-k].
  - In slot 0, SDATA = previous frame's F[0].
- Reset values:
  - BCLK = 0, LRCLK = 1, bc = 2W-1, SDATA = 0, OVERRUN = 0.
  - HOLD = 8'h80, PENDING = 0, shifter = 0.
  - Divider = 0.
- RST mid-frame: all state returns to the reset values immediately (asynchronously). Any pending sample is discarded.

## Timing
- After RST deasserts:
  - BCLK rises at the HALF_DIV-th rising edge of CLK.
  - First fall event (frame start: LRCLK→0, bc = 0) occurs at edge 2·HALF_DIV.
- Latency: a sample strobed before a frame latch has its MSB on SDATA starting one BCLK period after that latch, i.e. 2·HALF_DIV CLK cycles later.
- Worst case from strobe to MSB: one frame plus one bit period = (2W+1)·2·HALF_DIV CLK cycles.
- OVERRUN is registered: it is high exactly one CLK cycle after the offending strobe.
- Default rates: NCO at 3125 clk/sample vs. frame at 3136 clk → occasional overrun is expected. The latest sample always wins.

## Configuration
- I2S_TX_UNDERRUN_MUTE_EN
  - Defined: at a frame latch with PENDING = 0 and no STB, the frame source is 8'h80 (C = 0, silence).
  - Undefined: the frame source is HOLD, so the last sample repeats.
  - Overrun behaviour is identical in both builds.

## Structure
- Shared package synth_audio_pkg:
  - SAMPLE_W = 8 and SAMPLE_MID = 8'h80.
  - Function u8_to_signed_lj(sample, width) implementing the conversion above.
  - The NCO and any future mixer use the same package.
- Sub-module i2s_bclk_gen (divider, BCLK toggle, fall-event strobe, async reset) is natural. Shifter, bit counter and holding logic stay in i2s_tx.

## Test plan
Configuration for all scenarios: HALF_DIV = 2, W = 16.

1. Reset: assert RST mid-operation → BCLK = 0, LRCLK = 1, SDATA = 0, OVERRUN = 0 immediately. After release, BCLK rises at CLK edge 2 and LRCLK falls at edge 4.
2. STB with 8'hC0 before the first frame → left and right words both 16'h4000. MSB appears one BCLK after LRCLK falls. LSB of right appears in slot 0 of the next frame.
3. Extremes: 8'h00 → 16'h8000; 8'hFF → 16'h7F00; 8'h80 → 16'h0000.
4. Overrun: STB 8'h10, then STB 8'h20 within the same frame → exactly one OVERRUN pulse, one cycle after the second strobe. Next frame carries 16'hA000.
5. Bypass: STB 8'h20 coincident with the frame-latch cycle → that frame carries 16'hA000 and OVERRUN stays 0.
6. Underrun: no strobe for one full frame after item 4 → next frame is 16'hA000 by default, or 16'h0000 with I2S_TX_UNDERRUN_MUTE_EN.
